// File: rtl/vga_line_fetch_arbiter.sv
// vga_line_fetch_arbiter
// Shares one single-port 1bpp pixel RAM between the display path and a writer.
// While the current line is on screen, the horizontal blank is used to prefetch
// the next visible line into the idle half of a ping-pong line buffer. At the
// end of each line the halves swap, and the new line is shifted out in step with
// the sync generator's locX/locY counters.
//
// Ports
//   PIXEL_CLK           pixel clock, the only clock
//   RESET               synchronous, active-high reset
//   locX, locY          sync generator counters
//   in_image            (locX,locY) lies in the visible area
//   mem_addr/en/we/wdata  RAM request port, driven in the cycle of the access
//   mem_rdata           RAM read data, valid the cycle after a read
//   wr_req/addr/data    writer request, held until wr_ack
//   wr_ack              pulses in the cycle the write is on the RAM port
//   pix_out, pix_valid  registered pixel stream (latency 1)
//   underrun            sticky: a line swap found its fetch still incomplete
//
// state | meaning
// IDLE  | RAM port free for the writer; waits for the fetch trigger at locX==RES_H
// FETCH | one read per cycle, base+k, k = 1..WORDS-1
// DRAIN | last read byte captured, fetch_done set; RAM port free for the writer

module vga_line_fetch_arbiter #(
  parameter int RES_H  = 640,
  parameter int RES_V  = 480,
  parameter int MAX_H  = 799,
  parameter int MAX_V  = 524,
  parameter int ADDR_W = 16
) (
  input  logic              PIXEL_CLK,
  input  logic              RESET,
  input  logic [12:0]       locX,
  input  logic [12:0]       locY,
  input  logic              in_image,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              pix_out,
  output logic              pix_valid,
  output logic              underrun
);

  localparam int WORDS = RES_H / 8;
  localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int KW    = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] base;
  logic              disp_sel;
  logic              fetch_done;
  logic              fetch_armed;   // a fetch was triggered on this line
  logic              rd_valid;      // a read was issued last cycle
  logic [WIDX-1:0]   rd_idx;        // fill-buffer slot of that read

  logic [7:0]        line_buf [2][WORDS];

  logic [12:0]       nxt_line;
  logic [ADDR_W-1:0] base_next;
  logic              trig;
  logic              rd_issue;
  logic              grant;
  logic [WIDX-1:0]   pix_word;
  logic [7:0]        pix_byte;

  // The RAM port is driven combinationally so a granted write and its ack sit
  // in the same cycle, and the trigger cycle itself already issues read 0.
  // Everything is gated with RESET so all outputs read 0 while it is asserted.
  always_comb begin
    nxt_line  = (locY == 13'(MAX_V)) ? 13'd0 : locY + 13'd1;
    base_next = ADDR_W'(nxt_line) * ADDR_W'(WORDS);
    trig      = !RESET && (state == IDLE) && (locX == 13'(RES_H)) &&
                (nxt_line < 13'(RES_V));
    rd_issue  = trig || (!RESET && (state == FETCH));
    grant     = !RESET && wr_req && !rd_issue;

    mem_en    = rd_issue || grant;
    mem_we    = grant;
    mem_wdata = grant ? wr_data : 8'h00;
    wr_ack    = grant;
    if (grant)
      mem_addr = wr_addr;
    else if (trig)
      mem_addr = base_next;
    else if (rd_issue)
      mem_addr = base + ADDR_W'(k);
    else
      mem_addr = '0;
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      state       <= IDLE;
      k           <= '0;
      base        <= '0;
      disp_sel    <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_armed <= 1'b0;
      underrun    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_idx      <= '0;
    end else begin
      rd_valid <= rd_issue;
      rd_idx   <= trig ? '0 : k[WIDX-1:0];

      case (state)
        IDLE: begin
          if (trig) begin
            base        <= base_next;
            k           <= KW'(1);
            fetch_done  <= 1'b0;
            fetch_armed <= 1'b1;
            state       <= (WORDS == 1) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          k <= k + KW'(1);
          if (k == KW'(WORDS - 1))
            state <= DRAIN;
        end
        DRAIN: begin
          fetch_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Line swap. Written after the FSM so a swap clears fetch_done last.
      if (locX == 13'(MAX_H) && fetch_armed) begin
        fetch_armed <= 1'b0;
        if (fetch_done) begin
          disp_sel   <= ~disp_sel;
          fetch_done <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

  // Buffer contents need no reset; RESET only blocks a pending capture.
  always_ff @(posedge PIXEL_CLK) begin
    if (!RESET && rd_valid)
      line_buf[~disp_sel][rd_idx] <= mem_rdata;
  end

  assign pix_word = locX[WIDX+2:3];
  assign pix_byte = line_buf[disp_sel][pix_word];

  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      pix_out   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= in_image;
      pix_out   <= (in_image && locX < 13'(RES_H)) ? pix_byte[3'd7 - locX[2:0]] : 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
module tb_vga_line_fetch_arbiter;

  logic        PIXEL_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [12:0] locX = '0;
  logic [12:0] locY = '0;
  logic        in_image = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        pix_out;
  logic        pix_valid;
  logic        underrun;

  vga_line_fetch_arbiter dut (
    .PIXEL_CLK (PIXEL_CLK),
    .RESET     (RESET),
    .locX      (locX),
    .locY      (locY),
    .in_image  (in_image),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .underrun  (underrun)
  );

  always #5 PIXEL_CLK = ~PIXEL_CLK;

  // RAM model: line 0 holds 0x80,0x00,...; every other byte a holds a[7:0].
  logic [7:0] ram [65536];
  logic       ram_load = 1'b0;

  always @(posedge PIXEL_CLK) begin
    if (ram_load) begin
      for (int a = 0; a < 65536; a++)
        ram[a] <= (a < 80) ? ((a == 0) ? 8'h80 : 8'h00) : 8'(a);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int total = 0;
  int bad = 0;

  logic rst_drive = 1'b1;
  int   wr_arm_x = -1, wr_arm_y = -1;
  logic wr_pend = 1'b0;
  logic [15:0] wr_a_next = '0;
  logic [7:0]  wr_d_next = '0;

  int rd_cnt, rd_runs, rd_first, rd_last, rd_first_x;
  int ack_cnt, ack_x, pix_ones, pix_last_x;
  logic prev_rd;
  logic pix_arr [800];
  logic pv_arr [800];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; rd_runs = 0; rd_first = -1; rd_last = -1; rd_first_x = -1;
    ack_cnt = 0; ack_x = -1; pix_ones = 0; pix_last_x = -1; prev_rd = 1'b0;
    for (int i = 0; i < 800; i++) begin
      pix_arr[i] = 1'b0;
      pv_arr[i]  = 1'b0;
    end
  endtask

  // One pixel cycle: inputs change just after the edge, outputs observed at negedge.
  task automatic tick(input int x, input int y);
    @(posedge PIXEL_CLK);
    #1;
    RESET    = rst_drive;
    locX     = 13'(x);
    locY     = 13'(y);
    in_image = (x < 640) && (y < 480);
    if (x == wr_arm_x && y == wr_arm_y) begin
      wr_pend = 1'b1;
      wr_addr = wr_a_next;
      wr_data = wr_d_next;
    end
    wr_req = wr_pend;
    @(negedge PIXEL_CLK);
    if (mem_en && !mem_we) begin
      if (rd_cnt == 0) begin
        rd_first   = int'(mem_addr);
        rd_first_x = x;
      end
      rd_last = int'(mem_addr);
      if (!prev_rd) rd_runs++;
      rd_cnt++;
    end
    prev_rd = mem_en && !mem_we;
    if (wr_ack) begin
      ack_cnt++;
      ack_x   = x;
      wr_pend = 1'b0;
    end
    if (pix_out === 1'b1) begin
      pix_ones++;
      pix_last_x = x;
    end
    if (x >= 0 && x < 800) begin
      pix_arr[x] = pix_out;
      pv_arr[x]  = pix_valid;
    end
  endtask

  task automatic run_seg(input int y, input int x0, input int x1);
    clear_stats();
    for (int x = x0; x <= x1; x++) tick(x, y);
  endtask

  function automatic int pop_range(input int a0, input int n);
    int s;
    s = 0;
    for (int a = a0; a < a0 + n; a++) s += $countones(ram[a]);
    return s;
  endfunction

  initial begin
    clear_stats();
    // reset
    rst_drive = 1'b1;
    ram_load  = 1'b1;
    tick(700, 478);
    ram_load  = 1'b0;
    tick(701, 478);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst_drive = 1'b0;

    // vertical blank lines never fetch
    run_seg(479, 630, 660);
    chk("vblank479_reads", rd_cnt, 0);
    run_seg(523, 630, 660);
    chk("vblank523_reads", rd_cnt, 0);

    // line 524 prefetches line 0
    run_seg(524, 630, 799);
    chk("l524_reads", rd_cnt, 80);
    chk("l524_runs", rd_runs, 1);
    chk("l524_first_addr", rd_first, 0);
    chk("l524_last_addr", rd_last, 79);
    chk("l524_first_x", rd_first_x, 640);
    chk("l524_underrun", 32'(underrun), 0);

    // line 0: shows 0x80,0x00,... and prefetches line 1
    run_seg(0, 0, 799);
    chk("l0_reads", rd_cnt, 80);
    chk("l0_first_addr", rd_first, 80);
    chk("l0_last_addr", rd_last, 159);
    chk("l0_first_x", rd_first_x, 640);
    chk("l0_pix_ones", pix_ones, 1);
    chk("l0_pix_one_x", pix_last_x, 1);
    chk("l0_pv_x0", 32'(pv_arr[0]), 0);
    chk("l0_pv_x1", 32'(pv_arr[1]), 1);
    chk("l0_pv_x641", 32'(pv_arr[641]), 0);

    // line 1: writer request just before the trigger
    wr_arm_x = 639; wr_arm_y = 1; wr_a_next = 16'h0100; wr_d_next = 8'hFF;
    run_seg(1, 0, 799);
    chk("l1_pix_ones", pix_ones, pop_range(80, 80));
    chk("l1_ack_cnt", ack_cnt, 1);
    chk("l1_ack_x", ack_x, 639);
    chk("l1_first_x", rd_first_x, 640);
    chk("l1_first_addr", rd_first, 160);
    chk("l1_reads", rd_cnt, 80);
    chk("l1_ram_0100", 32'(ram[16'h0100]), 32'hFF);

    // line 2: writer request mid-fetch waits for the drain cycle
    wr_arm_x = 641; wr_arm_y = 2; wr_a_next = 16'h0200; wr_d_next = 8'hA5;
    run_seg(2, 0, 799);
    chk("l2_ack_cnt", ack_cnt, 1);
    chk("l2_ack_x", ack_x, 720);
    chk("l2_reads", rd_cnt, 80);
    chk("l2_runs", rd_runs, 1);
    chk("l2_first_addr", rd_first, 240);
    chk("l2_ram_0200", 32'(ram[16'h0200]), 32'hA5);
    wr_arm_x = -1; wr_arm_y = -1;

    // line 3: jump to the line end while line 4's fetch is still running
    run_seg(3, 0, 650);
    tick(799, 3);
    run_seg(4, 0, 659);
    chk("l4_underrun", 32'(underrun), 1);
    chk("l4_pix_x1", 32'(pix_arr[1]), 1);
    chk("l4_pix_ones", pix_ones, pop_range(240, 80));

    // reset during line 5's fetch
    rst_drive = 1'b1;
    tick(660, 4);
    rst_drive = 1'b0;
    tick(661, 4);
    chk("rst_mid_mem_en", 32'(mem_en), 0);
    chk("rst_mid_underrun", 32'(underrun), 0);
    run_seg(4, 662, 799);
    chk("rst_mid_reads", rd_cnt, 0);
    chk("rst_mid_underrun_end", 32'(underrun), 0);

    // the next line's trigger restarts normally
    run_seg(5, 630, 799);
    chk("l5_reads", rd_cnt, 80);
    chk("l5_first_addr", rd_first, 480);
    chk("l5_first_x", rd_first_x, 640);
    chk("l5_underrun", 32'(underrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
